// File: rtl/stoch_bit_accumulator.sv
// Counts the 1s of a qualified stochastic bitstream over a window of 2^n enabled
// samples and hands the total to a consumer through a valid/ready handshake.
module stoch_bit_accumulator #(
    parameter int n  = 7,
    parameter int n2 = 2**n
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_en,
    input  logic       count_ready,
    output logic [n:0] count,
    output logic       count_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [n-1:0] smp_cnt;
    logic         smp_last;
    logic         xfer;
    logic         win_clear;
    logic         win_step;
    logic         valid_nxt;
    logic         busy_nxt;

    // Window end is the terminal value of the n-bit sample counter.
    assign smp_last  = (smp_cnt == n'(n2 - 1));
    assign xfer      = (state == HOLD) && count_ready;
    assign win_clear = ((state == IDLE) && start) || (xfer && start);
    assign win_step  = (state == ACCUM) && bit_en;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (bit_en && smp_last) state_nxt = HOLD;
            HOLD:    if (count_ready) state_nxt = start ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Flags are registered alongside the state so they carry no input-to-output path.
    always_comb begin
        valid_nxt = (state_nxt == HOLD);
        busy_nxt  = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            count_valid <= valid_nxt;
            busy        <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            smp_cnt <= '0;
        end else if (win_clear) begin
            count   <= '0;
            smp_cnt <= '0;
        end else if (win_step) begin
            count   <= count + {{n{1'b0}}, bit_in};
            smp_cnt <= smp_cnt + n'(1);
        end
    end

endmodule

// File: tb/tb_stoch_bit_accumulator.sv
// Bench for stoch_bit_accumulator: table-driven windows, randomized windows against
// an enabled-sample counting model, and hand-written handshake/reset sequences.
module tb_stoch_bit_accumulator;

    localparam int N    = 7;
    localparam int W    = 1 << N;
    localparam int MAXC = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_en = 1'b0;
    logic       count_ready = 1'b1;
    logic [N:0] count;
    logic       count_valid;
    logic       busy;

    int tests = 0;
    int fails = 0;

    bit stim_en  [MAXC+1];
    bit stim_bit [MAXC+1];

    typedef struct {
        int mode;       // 0 all ones, 1 all zeros, 2 alternating over enabled samples
        int en_period;  // 0 always enabled, else bit_en low when cycle % en_period == 0
        int exp_cnt;
        int exp_lat;
    } vec_t;

    vec_t vecs [6];

    stoch_bit_accumulator #(.n(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bit_in      (bit_in),
        .bit_en      (bit_en),
        .count_ready (count_ready),
        .count       (count),
        .count_valid (count_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Disabled cycles carry random bits: they must never be counted.
    task automatic build(input int mode, input int en_period);
        int j = 0;
        for (int k = 1; k <= MAXC; k++) begin
            if (mode == 3) stim_en[k] = (k >= 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
            else           stim_en[k] = (en_period == 0) || (k % en_period != 0);
            if (!stim_en[k]) begin
                stim_bit[k] = 1'($urandom_range(0, 1));
            end else begin
                case (mode)
                    0:       stim_bit[k] = 1'b1;
                    1:       stim_bit[k] = 1'b0;
                    2:       stim_bit[k] = (j % 2 == 0);
                    default: stim_bit[k] = 1'($urandom_range(0, 1));
                endcase
                j++;
            end
        end
    endtask

    // Reference: take the first W enabled samples; latency is the cycle of the last one.
    task automatic model(output int ones, output int lat);
        int c = 0;
        ones = 0;
        lat  = 0;
        for (int k = 1; k <= MAXC; k++) begin
            if (stim_en[k] && c < W) begin
                c++;
                ones += int'(stim_bit[k]);
                if (c == W) lat = k;
            end
        end
    endtask

    // Called at a negedge right after the window-opening edge.
    task automatic wait_valid(input string nm, input int exp_cnt, input int exp_lat, input bit noise);
        int lat = 0;
        bit got = 0;
        for (int k = 1; k <= MAXC && !got; k++) begin
            bit_en = stim_en[k];
            bit_in = stim_bit[k];
            start  = noise && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (count_valid) begin
                got = 1;
                lat = k;
            end
        end
        start = 1'b0;
        chk($sformatf("%s valid_seen", nm), int'(got), 1);
        chk($sformatf("%s count", nm), int'(count), exp_cnt);
        chk($sformatf("%s latency", nm), lat, exp_lat);
        chk($sformatf("%s busy_hold", nm), int'(busy), 1);
    endtask

    task automatic run_window(input string nm, input int exp_cnt, input int exp_lat,
                              input bit noise, input bit rdy);
        count_ready = rdy;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("%s busy_start", nm), int'(busy), 1);
        wait_valid(nm, exp_cnt, exp_lat, noise);
        if (rdy) begin
            bit_en = 1'b1;
            bit_in = 1'b1;
            @(negedge clk);
            chk($sformatf("%s valid_drop", nm), int'(count_valid), 0);
            chk($sformatf("%s idle", nm), int'(busy), 0);
            chk($sformatf("%s count_kept", nm), int'(count), exp_cnt);
        end
    endtask

    initial begin
        int ones;
        int lat;

        vecs[0] = '{0, 0, 128, 128};
        vecs[1] = '{1, 0,   0, 128};
        vecs[2] = '{2, 4,  64, 170};
        vecs[3] = '{0, 4, 128, 170};
        vecs[4] = '{0, 2, 128, 255};
        vecs[5] = '{1, 3,   0, 191};

        repeat (3) @(negedge clk);
        chk("reset count", int'(count), 0);
        chk("reset valid", int'(count_valid), 0);
        chk("reset busy", int'(busy), 0);
        rst = 1'b0;

        // IDLE must ignore samples entirely.
        bit_en = 1'b1;
        bit_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle busy", int'(busy), 0);
        chk("idle count", int'(count), 0);

        for (int i = 0; i < 6; i++) begin
            build(vecs[i].mode, vecs[i].en_period);
            run_window($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_lat, 1'b0, 1'b1);
        end

        for (int i = 0; i < 6; i++) begin
            build(3, 0);
            model(ones, lat);
            run_window($sformatf("rand%0d", i), ones, lat, 1'b1, 1'b1);
        end

        // Backpressure: result held, start ignored until ready.
        build(0, 0);
        run_window("bp", 128, 128, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            start  = (i % 5 == 0);
            bit_en = 1'b1;
            bit_in = 1'b0;
            @(negedge clk);
            chk($sformatf("bp valid%0d", i), int'(count_valid), 1);
            chk($sformatf("bp count%0d", i), int'(count), 128);
        end
        start = 1'b0;
        count_ready = 1'b1;
        @(negedge clk);
        chk("bp release valid", int'(count_valid), 0);
        chk("bp release busy", int'(busy), 0);
        chk("bp release count", int'(count), 128);

        // Back-to-back: transfer and start on the same edge.
        build(0, 0);
        run_window("b2b_a", 128, 128, 1'b0, 1'b0);
        count_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b restart busy", int'(busy), 1);
        chk("b2b restart valid", int'(count_valid), 0);
        chk("b2b restart count", int'(count), 0);
        build(1, 0);
        wait_valid("b2b_b", 0, 128, 1'b0);
        @(negedge clk);
        chk("b2b end idle", int'(busy), 0);

        // Reset in the middle of a window.
        build(0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            bit_en = 1'b1;
            bit_in = 1'b1;
            @(negedge clk);
        end
        chk("mid count50", int'(count), 50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst count", int'(count), 0);
        chk("mid rst valid", int'(count_valid), 0);
        chk("mid rst busy", int'(busy), 0);
        build(2, 4);
        run_window("post_rst", 64, 170, 1'b0, 1'b1);

        // Reset while holding a result.
        build(0, 0);
        run_window("hold_rst", 128, 128, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_ready = 1'b1;
        chk("hold rst valid", int'(count_valid), 0);
        chk("hold rst count", int'(count), 0);
        chk("hold rst busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
